// File: rtl/temp_sensor_rx_pkg.sv
// Shared definitions for the Smart_Home temperature receive path.
package smart_home_pkg;

  localparam int unsigned TEMP_W = 5;

  localparam logic [TEMP_W-1:0] DEFAULT_TEMP = 5'd20;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/temp_sensor_rx_avg.sv
// Power-of-two moving average over accepted temperature samples.
// Holds the ring buffer, running sum and registered average output.
module temp_avg
  import smart_home_pkg::*;
#(
  parameter int unsigned       AVG_LOG2   = 2,
  parameter logic [TEMP_W-1:0] RESET_TEMP = DEFAULT_TEMP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [TEMP_W-1:0] in_data,
  output logic [TEMP_W-1:0] avg,
  output logic              avg_valid
);

  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned PTR_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam int unsigned SUM_W = TEMP_W + AVG_LOG2;
  localparam int unsigned EXT_W = SUM_W + 1;

  logic [TEMP_W-1:0] ring_q [DEPTH];
  logic [TEMP_W-1:0] ring_d [DEPTH];
  logic [PTR_W-1:0]  wp_q, wp_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [TEMP_W-1:0] avg_q, avg_d;
  logic              avg_valid_q, avg_valid_d;
  logic [EXT_W-1:0]  sum_ext;
  logic [SUM_W-1:0]  sum_shifted;

  // Replace the oldest entry with the new sample and update sum/average together
  always_comb begin
    ring_d      = ring_q;
    wp_d        = wp_q;
    sum_d       = sum_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    sum_ext     = EXT_W'(sum_q) - EXT_W'(ring_q[wp_q]) + EXT_W'(in_data);
    sum_shifted = sum_ext[SUM_W-1:0] >> AVG_LOG2;
    if (in_valid) begin
      ring_d[wp_q] = in_data;
      sum_d        = sum_ext[SUM_W-1:0];
      avg_d        = sum_shifted[TEMP_W-1:0];
      avg_valid_d  = 1'b1;
      if (wp_q == PTR_W'(DEPTH - 1)) begin
        wp_d = '0;
      end else begin
        wp_d = wp_q + PTR_W'(1);
      end
    end
  end

  // State registers; reset seeds every entry so the average starts at RESET_TEMP
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ring_q[i] <= RESET_TEMP;
      end
      wp_q        <= '0;
      sum_q       <= SUM_W'(RESET_TEMP) << AVG_LOG2;
      avg_q       <= RESET_TEMP;
      avg_valid_q <= 1'b0;
    end else begin
      ring_q      <= ring_d;
      wp_q        <= wp_d;
      sum_q       <= sum_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
    end
  end

  assign avg       = avg_q;
  assign avg_valid = avg_valid_q;

endmodule

// File: rtl/temp_sensor_rx.sv
// Serial temperature frame receiver: start, 5 data bits LSB first, even
// parity, stop. Accepted samples feed the moving-average filter.
module temp_sensor_rx
  import smart_home_pkg::*;
#(
  parameter int unsigned       AVG_LOG2   = 2,
  parameter logic [TEMP_W-1:0] RESET_TEMP = DEFAULT_TEMP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sdata,
  output logic [TEMP_W-1:0] temperature,
  output logic              temp_valid,
  output logic              parity_err,
  output logic              frame_err
);

  rx_state_t         state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [TEMP_W-1:0] shift_q, shift_d;
  logic              parity_bit_q, parity_bit_d;
  logic [TEMP_W-1:0] sample_q, sample_d;
  logic              sample_rdy_q, sample_rdy_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;

  // Frame FSM: parity is judged first, so a bad-parity frame never reports a stop error
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_bit_d = parity_bit_q;
    sample_d     = sample_q;
    sample_rdy_d = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!sdata) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        shift_d   = {sdata, shift_q[TEMP_W-1:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd4) begin
          state_d = PARITY;
        end
      end
      PARITY: begin
        parity_bit_d = sdata;
        state_d      = STOP;
      end
      STOP: begin
        state_d = IDLE;
        if ((^shift_q) != parity_bit_q) begin
          parity_err_d = 1'b1;
        end else if (sdata) begin
          sample_rdy_d = 1'b1;
          sample_d     = shift_q;
        end else begin
          frame_err_d = 1'b1;
          state_d     = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (sdata) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Receiver registers; reset drops any partial frame and any pending sample
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_bit_q <= 1'b0;
      sample_q     <= '0;
      sample_rdy_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_bit_q <= parity_bit_d;
      sample_q     <= sample_d;
      sample_rdy_q <= sample_rdy_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  temp_avg #(
    .AVG_LOG2  (AVG_LOG2),
    .RESET_TEMP(RESET_TEMP)
  ) u_avg (
    .clk      (clk),
    .rst      (rst),
    .in_valid (sample_rdy_q),
    .in_data  (sample_q),
    .avg      (temperature),
    .avg_valid(temp_valid)
  );

  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule
